// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet tile sequencer.
//   state_t   : sequencer phases (3-bit encoding)
//   SRAM_LAT  : read latency of the activation/weight SRAM in cycles
//   flush_len : cycles needed for data to cross a row x col PE array
package corelet_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KW   = 3'd1,
    KL   = 3'd2,
    AW   = 3'd3,
    EX   = 3'd4,
    DR   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int SRAM_LAT = 1;

  function automatic int flush_len(input int r, input int c);
    return r + c;
  endfunction

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable up-counter used for the sequencer's issue index, phase cycle
// count and psum index.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : synchronous clear (priority over load/en)
//   load/load_val: parallel load
//   en           : count enable
//   tc_val/tc    : terminal-count compare value and flag (cnt == tc_val)
//   cnt          : current count
module ctrl_cnt
  import corelet_ctrl_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/corelet_ctrl.sv
// Tile sequencer for one corelet: weight fetch into L0, weight load into the
// PE array, activation fetch, execute, then OFIFO drain through the SFP into
// psum SRAM. Every output is a register; the combinational block computes
// the value each output takes after the next clock edge.
//   clk, reset                 : clock, synchronous active-high reset
//   start, num_act             : tile request and activation count (1..l0_depth)
//   w_base, a_base, p_base     : weight, activation and psum base addresses
//   xmem_cen, xmem_addr        : activation/weight SRAM read port
//   l0_wr, l0_rd, l0_full      : L0 write/read strobes and full flag
//   load, execute              : corelet instructions
//   ofifo_valid, ofifo_rd      : OFIFO handshake
//   sfu_enable                 : SFP accumulate/ReLU enable
//   pmem_wen, pmem_addr        : psum SRAM write port
//   busy, done, err            : status (done/err are one-cycle pulses)
module corelet_ctrl
  import corelet_ctrl_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int l0_depth = 64,
  parameter int addr_w   = 11,
  parameter int cnt_w    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_w-1:0]  num_act,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] a_base,
  input  logic [addr_w-1:0] p_base,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              load,
  output logic              execute,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  output logic              sfu_enable,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int FLUSH = flush_len(row, col);
  // Phase counter must reach num_act + row + col - 1.
  localparam int PW = cnt_w + 1;

  state_t state, state_n;

  logic [cnt_w-1:0]  num_q;
  logic [addr_w-1:0] w_base_q, a_base_q, p_base_q;

  logic [cnt_w-1:0] i_cnt, i_tc_val;
  logic             i_clr, i_en, i_tc;
  logic [PW-1:0]    k_cnt, k_tc_val, k_act_len;
  logic             k_clr, k_en, k_tc;
  logic [cnt_w-1:0] j_cnt, j_tc_val;
  logic             j_clr, j_en, j_tc;

  logic              cen_n, rd_n, load_n, exec_n, ofrd_n, sfu_n, pwen_n;
  logic              busy_n, done_n, err_n, start_ok;
  logic [addr_w-1:0] addr_n, paddr_n, fbase;
  logic [SRAM_LAT-1:0] wr_sr;

  assign start_ok  = start && (num_act != '0) && (num_act <= cnt_w'(l0_depth));
  assign fbase     = (state == KW) ? w_base_q : a_base_q;

  // Issue index terminates at row in KW, at num_act in AW and DR (DR reuses
  // it to count OFIFO reads).
  assign i_tc_val  = (state == KW) ? cnt_w'(row) : num_q;
  assign k_act_len = (state == KL) ? PW'(row) : PW'(num_q);
  assign k_tc_val  = k_act_len + PW'(FLUSH) - PW'(1);
  assign j_tc_val  = num_q - cnt_w'(1);

  ctrl_cnt #(.W(cnt_w)) u_issue (
    .clk(clk), .reset(reset), .clr(i_clr), .load(1'b0), .load_val('0),
    .en(i_en), .tc_val(i_tc_val), .cnt(i_cnt), .tc(i_tc)
  );

  ctrl_cnt #(.W(PW)) u_phase (
    .clk(clk), .reset(reset), .clr(k_clr), .load(1'b0), .load_val('0),
    .en(k_en), .tc_val(k_tc_val), .cnt(k_cnt), .tc(k_tc)
  );

  ctrl_cnt #(.W(cnt_w)) u_psum (
    .clk(clk), .reset(reset), .clr(j_clr), .load(1'b0), .load_val('0),
    .en(j_en), .tc_val(j_tc_val), .cnt(j_cnt), .tc(j_tc)
  );

  always_comb begin
    state_n = state;
    i_clr   = 1'b0;
    i_en    = 1'b0;
    k_clr   = 1'b0;
    k_en    = 1'b0;
    j_clr   = 1'b0;
    j_en    = 1'b0;
    cen_n   = 1'b0;
    addr_n  = '0;
    rd_n    = 1'b0;
    load_n  = 1'b0;
    exec_n  = 1'b0;
    ofrd_n  = 1'b0;
    sfu_n   = 1'b0;
    pwen_n  = 1'b0;
    paddr_n = '0;
    busy_n  = (state != IDLE);
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        i_clr = 1'b1;
        k_clr = 1'b1;
        j_clr = 1'b1;
        if (start) begin
          if (start_ok) state_n = KW;
          else          err_n   = 1'b1;
        end
      end

      // The cycle after the last issue its l0_wr is on the wire, so moving
      // on here puts the first L0 read right after the last L0 write.
      KW, AW: begin
        if (i_tc) begin
          i_clr   = 1'b1;
          state_n = (state == KW) ? KL : EX;
        end else begin
          addr_n = fbase + addr_w'(i_cnt);
          if (!l0_full) begin
            cen_n = 1'b1;
            i_en  = 1'b1;
          end
        end
      end

      // Active cycles first, then row+col quiet cycles for array flush.
      KL, EX: begin
        k_en = 1'b1;
        if (k_cnt < k_act_len) begin
          rd_n   = 1'b1;
          load_n = (state == KL);
          exec_n = (state == EX);
        end
        if (k_tc) begin
          k_clr   = 1'b1;
          k_en    = 1'b0;
          state_n = (state == KL) ? AW : DR;
        end
      end

      // ofifo_rd -> sfu_enable -> pmem_wen, one register stage each.
      DR: begin
        if (!i_tc && ofifo_valid) begin
          ofrd_n = 1'b1;
          i_en   = 1'b1;
        end
        sfu_n  = ofifo_rd;
        pwen_n = sfu_enable;
        if (sfu_enable) begin
          paddr_n = p_base_q + addr_w'(j_cnt);
          j_en    = 1'b1;
          if (j_tc) state_n = DONE;
        end
      end

      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      xmem_cen   <= 1'b0;
      xmem_addr  <= '0;
      wr_sr      <= '0;
      l0_rd      <= 1'b0;
      load       <= 1'b0;
      execute    <= 1'b0;
      ofifo_rd   <= 1'b0;
      sfu_enable <= 1'b0;
      pmem_wen   <= 1'b0;
      pmem_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      xmem_cen   <= cen_n;
      xmem_addr  <= addr_n;
      wr_sr      <= SRAM_LAT'({wr_sr, xmem_cen});
      l0_rd      <= rd_n;
      load       <= load_n;
      execute    <= exec_n;
      ofifo_rd   <= ofrd_n;
      sfu_enable <= sfu_n;
      pmem_wen   <= pwen_n;
      pmem_addr  <= paddr_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

  // Read data lands SRAM_LAT cycles after xmem_cen; L0 write follows it.
  assign l0_wr = wr_sr[SRAM_LAT-1];

  // Tile parameters are captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_ok) begin
      num_q    <= num_act;
      w_base_q <= w_base;
      a_base_q <= a_base;
      p_base_q <= p_base;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: transaction-level reference model of
// the tile sequence (address lists, pulse counts, pipeline lags) with
// randomized tile parameters and OFIFO valid patterns.
module tb_corelet_ctrl;
  localparam int ROW = 8, COL = 8, DEPTH = 64, AW = 11, CW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, l0_full = 1'b0, ofifo_valid = 1'b0;
  logic [CW-1:0] num_act = '0;
  logic [AW-1:0] w_base = '0, a_base = '0, p_base = '0;
  logic xmem_cen, l0_wr, l0_rd, load, execute, ofifo_rd, sfu_enable, pmem_wen;
  logic busy, done, err;
  logic [AW-1:0] xmem_addr, pmem_addr;

  corelet_ctrl #(.row(ROW), .col(COL), .l0_depth(DEPTH), .addr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .w_base(w_base), .a_base(a_base), .p_base(p_base),
    .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .load(load), .execute(execute), .l0_full(l0_full),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .sfu_enable(sfu_enable),
    .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;

  // Observations collected by run_tile.
  logic [AW-1:0] addr_q[$], paddr_q[$];
  int n_wr, n_load, n_exec, n_done, n_err, n_rd, viol, stall_seen, stall_bad;
  int last_load, first_a, timeout;
  logic done_busy, post_busy, post_zero, zero_ok;

  function automatic bit all_zero();
    return ({xmem_cen, l0_wr, l0_rd, load, execute, ofifo_rd, sfu_enable,
             pmem_wen, busy, done, err} === 11'b0) &&
           (xmem_addr === '0) && (pmem_addr === '0);
  endfunction

  // Model: weights at wb+0..ROW-1, then activations at ab+0..num-1, mod 2^AW.
  function automatic int addr_mismatches(input int num, input logic [AW-1:0] wb,
                                         input logic [AW-1:0] ab);
    int bad;
    logic [AW-1:0] e;
    bad = 0;
    if (addr_q.size() != ROW + num) return 1000 + addr_q.size();
    for (int i = 0; i < ROW + num; i++) begin
      e = (i < ROW) ? AW'(wb + AW'(i)) : AW'(ab + AW'(i - ROW));
      if (addr_q[i] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int paddr_mismatches(input int num, input logic [AW-1:0] pb);
    int bad;
    bad = 0;
    if (paddr_q.size() != num) return 1000 + paddr_q.size();
    for (int i = 0; i < num; i++)
      if (paddr_q[i] !== AW'(pb + AW'(i))) bad++;
    return bad;
  endfunction

  // Start one tile at the current negedge and observe it cycle by cycle.
  task automatic run_tile(input int num, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb, input int stall_i, input int stall_len,
                          input int spur_cyc, input int rst_exec);
    logic prev_cen, prev_ofrd, prev_sfu, prev_valid, full_prev, in_rst, seen_done;
    int stall_cnt, quiet, v;
    addr_q.delete(); paddr_q.delete();
    n_wr = 0; n_load = 0; n_exec = 0; n_done = 0; n_err = 0; n_rd = 0; viol = 0;
    stall_seen = 0; stall_bad = 0; last_load = -1; first_a = -1; timeout = 1;
    done_busy = 0; post_busy = 1; post_zero = 0; zero_ok = 0;
    prev_cen = 0; prev_ofrd = 0; prev_sfu = 0; prev_valid = 0; full_prev = 0;
    in_rst = 0; seen_done = 0; stall_cnt = 0; quiet = 0; v = 0;
    start = 1; num_act = CW'(num); w_base = wb; a_base = ab; p_base = pb;
    @(negedge clk);
    start = 0; num_act = CW'($urandom); w_base = AW'($urandom);
    a_base = AW'($urandom); p_base = AW'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (in_rst) begin zero_ok = all_zero(); reset = 0; timeout = 0; break; end
      if (seen_done) begin post_busy = busy; post_zero = all_zero(); timeout = 0; break; end
      if (xmem_cen) begin
        addr_q.push_back(xmem_addr);
        if (addr_q.size() == ROW + 1) first_a = c;
      end
      if (l0_wr) n_wr++;
      if (load) begin n_load++; last_load = c; end
      if (execute) n_exec++;
      if (load && execute) viol++;
      if (l0_rd !== (load || execute)) viol++;
      if (l0_rd && (l0_wr || xmem_cen)) viol++;
      if (l0_wr !== prev_cen) viol++;
      if (sfu_enable !== prev_ofrd) viol++;
      if (pmem_wen !== prev_sfu) viol++;
      if (ofifo_rd !== (prev_valid && (n_rd < num))) viol++;
      if (ofifo_rd) n_rd++;
      if (pmem_wen) paddr_q.push_back(pmem_addr);
      if (err) n_err++;
      if (c > 0 && !busy) viol++;
      if (full_prev) begin
        stall_seen++;
        if (xmem_cen || xmem_addr !== AW'(ab + AW'(stall_i))) stall_bad++;
      end
      if (done) begin n_done++; done_busy = busy; seen_done = 1; end
      if (rst_exec > 0 && n_exec == rst_exec) begin reset = 1; in_rst = 1; end
      prev_cen = xmem_cen; prev_ofrd = ofifo_rd; prev_sfu = sfu_enable;
      if (stall_i >= 0 && addr_q.size() == ROW + stall_i && stall_cnt < stall_len) begin
        l0_full = 1; stall_cnt++;
      end else l0_full = 0;
      full_prev = l0_full;
      if (n_exec == num) quiet++;
      if (quiet > ROW + COL + 3) begin
        ofifo_valid = (v < 4) ? 1'(v % 3 == 0) : 1'($urandom_range(0, 1));
        v++;
      end else ofifo_valid = 0;
      prev_valid = ofifo_valid;
      start = (c == spur_cyc);
      if (start) num_act = CW'(5);
      @(negedge clk);
    end
    reset = 0; start = 0; l0_full = 0; ofifo_valid = 0;
  endtask

  task automatic test_reset();
    start = 1; num_act = 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_zero() !== 1'b1) begin
        errors++; $display("FAIL reset_outputs cycle %0d: nonzero outputs, required all 0", i);
      end
    end
    start = 0; reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    run_tile(4, 0, 16, 100, -1, 0, -1, -1);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timeout); end
    bad = addr_mismatches(4, 0, 16);
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_xaddr mismatches %0d want 0", bad); end
    checks++; if (n_wr !== ROW + 4) begin errors++; $display("FAIL basic_l0_wr got %0d want %0d", n_wr, ROW + 4); end
    checks++; if (n_load !== ROW) begin errors++; $display("FAIL basic_load got %0d want %0d", n_load, ROW); end
    checks++; if (n_exec !== 4) begin errors++; $display("FAIL basic_exec got %0d want 4", n_exec); end
    bad = paddr_mismatches(4, 100);
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_paddr mismatches %0d want 0", bad); end
    checks++; if (first_a - last_load - 1 !== ROW + COL) begin
      errors++; $display("FAIL basic_flush_gap got %0d want %0d", first_a - last_load - 1, ROW + COL); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL basic_protocol violations %0d want 0", viol); end
    checks++; if (n_done !== 1 || done_busy !== 1'b1) begin
      errors++; $display("FAIL basic_done count %0d busy %0b want 1/1", n_done, done_busy); end
    checks++; if (post_busy !== 1'b0 || post_zero !== 1'b1) begin
      errors++; $display("FAIL basic_idle busy %0b zero %0b want 0/1", post_busy, post_zero); end
  endtask

  task automatic test_invalid();
    int ne, nb, nc;
    for (int t = 0; t < 3; t++) begin
      ne = 0; nb = 0; nc = 0;
      start = 1; num_act = (t == 0) ? CW'(0) : (t == 1) ? CW'(65) : CW'($urandom_range(65, 127));
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 4; i++) begin
        if (err) ne++;
        if (busy) nb++;
        if (xmem_cen) nc++;
        @(negedge clk);
      end
      checks++; if (ne !== 1 || nb !== 0 || nc !== 0) begin
        errors++; $display("FAIL invalid_start%0d err %0d busy %0d cen %0d want 1/0/0", t, ne, nb, nc); end
    end
  endtask

  task automatic test_stall();
    int num, bad;
    logic [AW-1:0] wb, ab, pb;
    num = $urandom_range(4, 12); wb = AW'($urandom); ab = AW'($urandom); pb = AW'($urandom);
    run_tile(num, wb, ab, pb, 2, 5, -1, -1);
    bad = addr_mismatches(num, wb, ab);
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_xaddr mismatches %0d want 0", bad); end
    checks++; if (n_wr !== ROW + num) begin errors++; $display("FAIL stall_l0_wr got %0d want %0d", n_wr, ROW + num); end
    checks++; if (stall_seen !== 5 || stall_bad !== 0) begin
      errors++; $display("FAIL stall_hold seen %0d bad %0d want 5/0", stall_seen, stall_bad); end
    checks++; if (viol !== 0 || n_done !== 1) begin
      errors++; $display("FAIL stall_protocol viol %0d done %0d want 0/1", viol, n_done); end
  endtask

  task automatic test_drain();
    int num, bad;
    logic [AW-1:0] pb;
    for (int r = 0; r < 3; r++) begin
      num = $urandom_range(1, DEPTH); pb = AW'($urandom);
      run_tile(num, AW'($urandom), AW'($urandom), pb, -1, 0, -1, -1);
      bad = paddr_mismatches(num, pb);
      checks++; if (bad !== 0 || timeout !== 0) begin
        errors++; $display("FAIL drain%0d_paddr mismatches %0d timeout %0d want 0/0", r, bad, timeout); end
      checks++; if (viol !== 0 || n_rd !== num) begin
        errors++; $display("FAIL drain%0d_pipe viol %0d reads %0d want 0/%0d", r, viol, n_rd, num); end
    end
  endtask

  task automatic test_reset_ex();
    int bad;
    run_tile(6, 40, 200, 300, -1, 0, -1, 2);
    checks++; if (zero_ok !== 1'b1 || timeout !== 0) begin
      errors++; $display("FAIL reset_ex_outputs zero %0b timeout %0d want 1/0", zero_ok, timeout); end
    run_tile(5, 7, 77, 500, -1, 0, -1, -1);
    bad = addr_mismatches(5, 7, 77) + paddr_mismatches(5, 500);
    checks++; if (bad !== 0 || n_done !== 1 || viol !== 0) begin
      errors++; $display("FAIL reset_ex_rerun mismatches %0d done %0d viol %0d want 0/1/0", bad, n_done, viol); end
  endtask

  task automatic test_wrap();
    int bad;
    run_tile(4, 2046, 2045, 2046, -1, 0, 30, -1);
    bad = addr_mismatches(4, 2046, 2045);
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_xaddr mismatches %0d want 0", bad); end
    bad = paddr_mismatches(4, 2046);
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_paddr mismatches %0d want 0", bad); end
    checks++; if (n_err !== 0 || n_done !== 1 || post_busy !== 1'b0) begin
      errors++; $display("FAIL wrap_spurious err %0d done %0d busy %0b want 0/1/0", n_err, n_done, post_busy); end
  endtask

  task automatic test_bounds();
    int bad;
    run_tile(1, 5, 6, 7, -1, 0, -1, -1);
    bad = addr_mismatches(1, 5, 6) + paddr_mismatches(1, 7);
    checks++; if (bad !== 0 || n_exec !== 1 || viol !== 0) begin
      errors++; $display("FAIL bound_min mismatches %0d exec %0d viol %0d want 0/1/0", bad, n_exec, viol); end
    run_tile(DEPTH, 1000, 1500, 20, -1, 0, -1, -1);
    bad = addr_mismatches(DEPTH, 1000, 1500) + paddr_mismatches(DEPTH, 20);
    checks++; if (bad !== 0 || n_exec !== DEPTH || viol !== 0 || n_err !== 0) begin
      errors++; $display("FAIL bound_max mismatches %0d exec %0d viol %0d err %0d", bad, n_exec, viol, n_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_stall();
    test_drain();
    test_reset_ex();
    test_wrap();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
